// File: rtl/complete_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : complete_arbiter_pkg                                        |
// | Brief  : Shared typedefs for the complete/writeback arbitration      |
// |          slice: ROB index width, FU indices, completion structs.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package complete_arbiter_pkg;

    // Width of robNum / rob_head; ages wrap modulo 2**ROB_SIZE_BITS.
    localparam int ROB_SIZE_BITS = 4;

    // Number of functional units feeding the complete stage.
    localparam int NUM_FU = 3;

    typedef enum logic [1:0] {
        FU_ALU1 = 2'd0,
        FU_ALU2 = 2'd1,
        FU_MEM  = 2'd2
    } fuIdx;

    typedef struct packed {
        logic RegWrite;
        logic MemWrite;
    } ctrlStruct;

    typedef struct packed {
        logic                     valid;
        logic [ROB_SIZE_BITS-1:0] robNum;
        logic [4:0]               rd;
        logic [31:0]              result;
        ctrlStruct                control;
    } completeStruct;

    typedef struct packed {
        logic alu1;
        logic alu2;
        logic mem;
    } fuRdyStruct;

endpackage : complete_arbiter_pkg
`default_nettype wire

// File: rtl/complete_arbiter_cmpl_hold_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cmpl_hold_slot                                              |
// | Brief  : One-entry completion holding register for a single FU.      |
// |          Accepts when empty or when being drained this cycle.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module cmpl_hold_slot
    import complete_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  completeStruct i_cmpl,
    input  logic          i_grant,
    output logic          o_rdy,
    output completeStruct o_held
);

    completeStruct r_slot;
    logic          w_accept;

    // Flush forces ready so a stalled FU is released while its data is squashed.
    assign o_rdy    = i_flush || !r_slot.valid || i_grant;
    assign w_accept = i_cmpl.valid && o_rdy && !i_flush;
    assign o_held   = r_slot;

    // Slot update: flush squashes, accept (re)loads, a grant without reload empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else if (i_flush) begin
            r_slot.valid <= 1'b0;
        end else if (w_accept) begin
            r_slot <= i_cmpl;
        end else if (i_grant) begin
            r_slot.valid <= 1'b0;
        end
    end

endmodule : cmpl_hold_slot
`default_nettype wire

// File: rtl/complete_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : complete_arbiter                                            |
// | Brief  : Holds one completion per FU and grants up to NUM_PORTS of   |
// |          them per cycle, oldest (relative to the ROB head) first.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module complete_arbiter
    import complete_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [ROB_SIZE_BITS-1:0] rob_head,
    input  completeStruct            alu1_cmpl,
    input  completeStruct            alu2_cmpl,
    input  completeStruct            mem_cmpl,
    output fuRdyStruct               fu_rdy,
    output completeStruct            cmpl_out [NUM_PORTS]
);

    localparam logic [2:0] c_num_ports = 3'(NUM_PORTS);

    completeStruct [NUM_FU-1:0]    w_in;
    completeStruct [NUM_FU-1:0]    w_held;
    logic          [NUM_FU-1:0]    w_rdy;
    logic          [NUM_FU-1:0]    w_grant;
    logic [ROB_SIZE_BITS-1:0]      w_age  [NUM_FU];
    logic [2:0]                    w_rank [NUM_FU];
    completeStruct [NUM_PORTS-1:0] w_port;
    completeStruct [NUM_PORTS-1:0] r_out;

    assign w_in[FU_ALU1] = alu1_cmpl;
    assign w_in[FU_ALU2] = alu2_cmpl;
    assign w_in[FU_MEM]  = mem_cmpl;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
        cmpl_hold_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (flush),
            .i_cmpl  (w_in[gi]),
            .i_grant (w_grant[gi]),
            .o_rdy   (w_rdy[gi]),
            .o_held  (w_held[gi])
        );
    end

    assign fu_rdy.alu1 = w_rdy[FU_ALU1];
    assign fu_rdy.alu2 = w_rdy[FU_ALU2];
    assign fu_rdy.mem  = w_rdy[FU_MEM];

    // Rank each valid slot by how many valid slots are older; equal ages fall
    // back to FU index order. Ranks below NUM_PORTS win a port of that number.
    always_comb begin
        for (int x = 0; x < NUM_FU; x++) begin
            w_age[x] = w_held[x].robNum - rob_head;
        end
        for (int x = 0; x < NUM_FU; x++) begin
            w_rank[x] = 3'd0;
            for (int y = 0; y < NUM_FU; y++) begin
                if ((y != x) && w_held[y].valid &&
                    ((w_age[y] < w_age[x]) || ((w_age[y] == w_age[x]) && (y < x)))) begin
                    w_rank[x] = w_rank[x] + 3'd1;
                end
            end
            w_grant[x] = w_held[x].valid && (w_rank[x] < c_num_ports);
        end
    end

    // Route each granted slot to the port matching its rank.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_port[k] = '0;
            for (int x = 0; x < NUM_FU; x++) begin
                if (w_grant[x] && (w_rank[x] == 3'(k))) begin
                    w_port[k] = w_held[x];
                end
            end
        end
    end

    // Output registers: squashed on flush, otherwise load this cycle's grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (flush) begin
            r_out <= '0;
        end else begin
            r_out <= w_port;
        end
    end

    for (genvar gk = 0; gk < NUM_PORTS; gk++) begin : g_out
        assign cmpl_out[gk] = r_out[gk];
    end

endmodule : complete_arbiter
`default_nettype wire

// File: tb/tb_complete_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_complete_arbiter                                         |
// | Brief  : Scoreboard bench for complete_arbiter: directed scenarios   |
// |          plus randomized traffic against a queue-based model.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    localparam int NP   = 2;
    localparam int RMOD = 1 << ROB_SIZE_BITS;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     flush = 1'b0;
    logic [ROB_SIZE_BITS-1:0] rob_head = '0;
    completeStruct            pres [NUM_FU];
    fuRdyStruct               fu_rdy;
    completeStruct            cmpl_out [NP];

    complete_arbiter #(.NUM_PORTS(NP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .rob_head  (rob_head),
        .alu1_cmpl (pres[0]),
        .alu2_cmpl (pres[1]),
        .mem_cmpl  (pres[2]),
        .fu_rdy    (fu_rdy),
        .cmpl_out  (cmpl_out)
    );

    always #5 clk = ~clk;

    typedef struct { int port; int cyc; completeStruct c; } exp_t;
    typedef struct { int fu; completeStruct c; } held_t;

    exp_t  exp_q [$];
    held_t held_q [$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    acc [NUM_FU];
    bit    done_rob [RMOD];
    int    alloc_q [$];
    int    next_rob  = 0;
    bit    auto_head = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int age_of(logic [ROB_SIZE_BITS-1:0] r);
        return (int'(r) - int'(rob_head) + RMOD) % RMOD;
    endfunction

    // Monitor: every valid output port must match the next expected entry,
    // including its port number and the cycle it was due.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < NP; k++) begin
                if (cmpl_out[k].valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL out_unexpected port%0d cyc=%0d got rob=%0d need nothing",
                                 k, cyc, cmpl_out[k].robNum);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.port != k || e.cyc != cyc || e.c != cmpl_out[k]) begin
                            n_err++;
                            $display("FAIL out_port%0d got rob=%0d res=%h rd=%0d port=%0d cyc=%0d, need rob=%0d res=%h rd=%0d port=%0d cyc=%0d",
                                     k, cmpl_out[k].robNum, cmpl_out[k].result, cmpl_out[k].rd, k, cyc,
                                     e.c.robNum, e.c.result, e.c.rd, e.port, e.cyc);
                        end
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL out_missing got nothing at cyc=%0d, need rob=%0d on port%0d at cyc=%0d",
                         cyc, e.c.robNum, e.port, e.cyc);
            end
        end
    end

    // Reference model for one cycle, evaluated just before the rising edge.
    task automatic model_eval();
        bit    taken [3];
        bit    rdy [NUM_FU];
        int    order [$];
        held_t keep [$];
        held_t h;
        exp_t  e;
        taken = '{default: 1'b0};
        // Pick the NP oldest held results, oldest first.
        for (int p = 0; p < NP; p++) begin
            int best;
            best = -1;
            for (int i = 0; i < held_q.size(); i++) begin
                if (!taken[i]) begin
                    if (best < 0) best = i;
                    else if (age_of(held_q[i].c.robNum) < age_of(held_q[best].c.robNum)) best = i;
                end
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                order.push_back(best);
            end
        end
        for (int f = 0; f < NUM_FU; f++) rdy[f] = 1'b1;
        for (int i = 0; i < held_q.size(); i++) if (!taken[i]) rdy[held_q[i].fu] = 1'b0;
        if (flush) for (int f = 0; f < NUM_FU; f++) rdy[f] = 1'b1;
        n_cmp++;
        if ({fu_rdy.alu1, fu_rdy.alu2, fu_rdy.mem} != {rdy[0], rdy[1], rdy[2]}) begin
            n_err++;
            $display("FAIL fu_rdy cyc=%0d got=%b need=%b", cyc,
                     {fu_rdy.alu1, fu_rdy.alu2, fu_rdy.mem}, {rdy[0], rdy[1], rdy[2]});
        end
        if (flush) begin
            for (int i = 0; i < held_q.size(); i++) done_rob[held_q[i].c.robNum] = 1'b1;
            held_q.delete();
            for (int f = 0; f < NUM_FU; f++) begin
                if (pres[f].valid) begin
                    acc[f] = 1'b1;
                    done_rob[pres[f].robNum] = 1'b1;
                end
            end
        end else begin
            for (int p = 0; p < order.size(); p++) begin
                e.port = p;
                e.cyc  = cyc + 1;
                e.c    = held_q[order[p]].c;
                exp_q.push_back(e);
                done_rob[e.c.robNum] = 1'b1;
            end
            for (int i = 0; i < held_q.size(); i++) if (!taken[i]) keep.push_back(held_q[i]);
            held_q = keep;
            for (int f = 0; f < NUM_FU; f++) begin
                if (pres[f].valid && rdy[f]) begin
                    h.fu = f;
                    h.c  = pres[f];
                    held_q.push_back(h);
                    acc[f] = 1'b1;
                end
            end
        end
    endtask

    task automatic update_head();
        while (alloc_q.size() > 0 && done_rob[alloc_q[0]]) void'(alloc_q.pop_front());
        rob_head = (alloc_q.size() > 0) ? ROB_SIZE_BITS'(alloc_q[0]) : ROB_SIZE_BITS'(next_rob);
    endtask

    // One clock: model at the falling edge, FU drivers react after the rising edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        for (int f = 0; f < NUM_FU; f++) begin
            if (acc[f]) begin
                pres[f].valid = 1'b0;
                acc[f] = 1'b0;
            end
        end
        if (auto_head) update_head();
    endtask

    task automatic present(int f, int r);
        pres[f].valid            = 1'b1;
        pres[f].robNum           = ROB_SIZE_BITS'(r);
        pres[f].rd               = 5'($urandom_range(0, 31));
        pres[f].result           = $urandom;
        pres[f].control.RegWrite = 1'($urandom_range(0, 1));
        pres[f].control.MemWrite = (f == 2) && !pres[f].control.RegWrite;
        done_rob[r] = 1'b0;
        alloc_q.push_back(r);
    endtask

    task automatic chk_port(string nm, int k, bit v, int r);
        n_cmp++;
        if (cmpl_out[k].valid !== v || (v && int'(cmpl_out[k].robNum) != r)) begin
            n_err++;
            $display("FAIL %s port%0d got valid=%b rob=%0d need valid=%b rob=%0d",
                     nm, k, cmpl_out[k].valid, cmpl_out[k].robNum, v, r);
        end
    endtask

    task automatic chk_bit(string nm, logic act, logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s got=%b need=%b", nm, act, req);
        end
    endtask

    task automatic random_phase(int n);
        auto_head = 1'b1;
        alloc_q.delete();
        next_rob = int'(rob_head);
        for (int c = 0; c < n; c++) begin
            int s;
            s = $urandom_range(0, 2);
            for (int i = 0; i < NUM_FU; i++) begin
                int f;
                f = (s + i) % NUM_FU;
                if (!pres[f].valid && $urandom_range(0, 99) < 60) begin
                    present(f, next_rob);
                    next_rob = (next_rob + 1) % RMOD;
                end
            end
            flush = ($urandom_range(0, 99) < 3);
            step();
            flush = 1'b0;
        end
        auto_head = 1'b0;
    endtask

    initial begin
        for (int f = 0; f < NUM_FU; f++) begin
            pres[f] = '0;
            acc[f]  = 1'b0;
        end
        // Reset state.
        #3;
        chk_port("rst_p0", 0, 1'b0, 0);
        chk_port("rst_p1", 1, 1'b0, 0);
        chk_bit("rst_rdy", &{fu_rdy.alu1, fu_rdy.alu2, fu_rdy.mem}, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single alu1 result, two-edge latency.
        rob_head = 4'd0;
        present(0, 5);
        step();
        step();
        chk_port("t1", 0, 1'b1, 5);
        chk_port("t1", 1, 1'b0, 0);

        // Three results, two ports: youngest waits one cycle.
        present(0, 3); present(1, 7); present(2, 1);
        step();
        chk_bit("t2_rdy_alu2_stall", fu_rdy.alu2, 1'b0);
        step();
        chk_port("t2_e2", 0, 1'b1, 1);
        chk_port("t2_e2", 1, 1'b1, 3);
        chk_bit("t2_rdy_alu2_free", fu_rdy.alu2, 1'b1);
        step();
        chk_port("t2_e3", 0, 1'b1, 7);
        chk_port("t2_e3", 1, 1'b0, 0);

        // Wrap-around ages with head=14.
        rob_head = 4'd14;
        present(0, 1); present(1, 15); present(2, 14);
        step();
        step();
        chk_port("t3_e2", 0, 1'b1, 14);
        chk_port("t3_e2", 1, 1'b1, 15);
        step();
        chk_port("t3_e3", 0, 1'b1, 1);

        // Back-to-back alu1 stream.
        rob_head = 4'd0;
        for (int i = 0; i < 10; i++) begin
            present(0, i);
            step();
            if (i >= 1) chk_port("t4_stream", 0, 1'b1, i - 1);
        end
        step();
        chk_port("t4_last", 0, 1'b1, 9);
        step();

        // Flush with all slots full; input presented during flush is dropped.
        present(0, 2); present(1, 4); present(2, 6);
        step();
        flush = 1'b1;
        present(0, 8);
        step();
        flush = 1'b0;
        chk_port("t5_flush", 0, 1'b0, 0);
        chk_port("t5_flush", 1, 1'b0, 0);
        step();
        step();
        chk_port("t5_idle", 0, 1'b0, 0);
        present(1, 9);
        step();
        step();
        chk_port("t5_new", 0, 1'b1, 9);
        step();

        // Randomized traffic, then an asynchronous reset mid-stream.
        rob_head = 4'd11;
        random_phase(200);
        #2;
        rst_n = 1'b0;
        #1;
        chk_port("t6_rst", 0, 1'b0, 0);
        chk_port("t6_rst", 1, 1'b0, 0);
        chk_bit("t6_rst_rdy", &{fu_rdy.alu1, fu_rdy.alu2, fu_rdy.mem}, 1'b1);
        exp_q.delete();
        held_q.delete();
        for (int f = 0; f < NUM_FU; f++) begin
            pres[f] = '0;
            acc[f]  = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rob_head = 4'd3;
        present(2, 4);
        step();
        chk_port("t6_lat1", 0, 1'b0, 0);
        step();
        chk_port("t6_lat2", 0, 1'b1, 4);
        step();

        random_phase(300);
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (exp_q.size() != 0 || held_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got pending_out=%0d held=%0d need 0 and 0", exp_q.size(), held_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_complete_arbiter
`default_nettype wire
